// File: rtl/sra_pkg.sv
// -----------------------------------------------------------------------------
// sra_pkg
// Shared constants and stage record types for the pipelined square-root
// approximation (SRA) magnitude unit:
//   |(a,b)| ~= max(x - x/8 + y/2, x),  x = max(|a|,|b|), y = min(|a|,|b|)
//
// Contents
//   SRA_SHIFT_X / SRA_SHIFT_Y : shift amounts for the x/8 and y/2 terms
//   SRA_WIDTH / SRA_TAG_W     : default operand and tag widths
//   sra_s1_t {x,y,tag}        : stage-1 record (sorted magnitudes)
//   sra_s2_t {x,p,q,tag}      : stage-2 record (scaled terms, x kept for the max)
//   sra_s3_t {mag,tag}        : stage-3 record (final estimate)
//   sra_round_shr()           : round-half-up right shift helper
//
// The record types are sized from the default widths. sra_pipe_unit builds
// the same three records locally from its own WIDTH/TAG_W parameters so that
// non-default widths remain fully supported.
// -----------------------------------------------------------------------------
package sra_pkg;

  localparam int SRA_SHIFT_X = 3;
  localparam int SRA_SHIFT_Y = 1;

  localparam int SRA_WIDTH = 16;
  localparam int SRA_TAG_W = 4;

  typedef struct packed {
    logic [SRA_WIDTH-1:0] x;
    logic [SRA_WIDTH-1:0] y;
    logic [SRA_TAG_W-1:0] tag;
  } sra_s1_t;

  typedef struct packed {
    logic [SRA_WIDTH-1:0] x;
    logic [SRA_WIDTH-1:0] p;
    logic [SRA_WIDTH-1:0] q;
    logic [SRA_TAG_W-1:0] tag;
  } sra_s2_t;

  typedef struct packed {
    logic [SRA_WIDTH:0]   mag;
    logic [SRA_TAG_W-1:0] tag;
  } sra_s3_t;

  // Round-half-up right shift of a 32-bit unsigned value: (v + 2^(s-1)) >> s.
  // The caller keeps v far enough below 2^32 that the bias cannot carry out.
  function automatic logic [31:0] sra_round_shr(input logic [31:0] v, input int s);
    logic [31:0] bias;
    bias = 32'd1 << (s - 1);
    return (v + bias) >> s;
  endfunction

endpackage

// File: rtl/sra_abs_sort.sv
// -----------------------------------------------------------------------------
// sra_abs_sort
// Combinational absolute value of two signed operands followed by a
// max/min sort.
//
// Ports
//   a, b : WIDTH-bit two's complement operands
//   x    : max(|a|,|b|) as WIDTH-bit unsigned
//   y    : min(|a|,|b|) as WIDTH-bit unsigned
//
// |-2^(WIDTH-1)| is 2^(WIDTH-1), which is representable as WIDTH-bit
// unsigned, so the negation never wraps into a wrong magnitude.
// -----------------------------------------------------------------------------
module sra_abs_sort #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  // Two's complement negation evaluated in unsigned WIDTH bits: the most
  // negative input maps onto 2^(WIDTH-1) rather than back to itself.
  assign abs_a = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign abs_b = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;

  // Equal magnitudes fall into the first branch and give x == y.
  assign x = (abs_a >= abs_b) ? abs_a : abs_b;
  assign y = (abs_a >= abs_b) ? abs_b : abs_a;

endmodule

// File: rtl/sra_pipe_unit.sv
// -----------------------------------------------------------------------------
// sra_pipe_unit
// Three-stage pipelined SRA magnitude estimator with valid/ready handshakes
// on both sides. Accepts one sample per cycle; latency is 3 cycles without
// stalls. A sideband tag travels with every sample, strictly in order.
//
//   S1: x = max(|a|,|b|), y = min(|a|,|b|)
//   S2: p = x - (x >> 3), q = y >> 1
//   S3: t = p + q (WIDTH+1 bits), mag = (t >= x) ? t : x
//
// Ports
//   clk, rst           : clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready  : input handshake, accept on in_valid && in_ready
//   in_a, in_b         : WIDTH-bit signed operands
//   in_tag             : TAG_W-bit sideband tag
//   out_valid/out_ready: output handshake, release on out_valid && out_ready
//   out_mag            : WIDTH+1-bit unsigned magnitude estimate
//   out_tag            : tag belonging to out_mag
//
// Build option
//   SRA_ROUND_EN : when defined, the two shifts round half-up,
//                  (x+4)>>3 and (y+1)>>1; otherwise they truncate. Latency
//                  and handshake behaviour are identical in both builds.
// -----------------------------------------------------------------------------
module sra_pipe_unit
  import sra_pkg::*;
#(
  parameter int WIDTH = SRA_WIDTH,
  parameter int TAG_W = SRA_TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH:0]     out_mag,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int WP1 = WIDTH + 1;

  // Stage records at this instance's widths (same layout as the package types).
  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] q;
    logic [TAG_W-1:0] tag;
  } s2_t;

  typedef struct packed {
    logic [WIDTH:0]   mag;
    logic [TAG_W-1:0] tag;
  } s3_t;

  s1_t s1_reg, s1_next;
  s2_t s2_reg, s2_next;
  s3_t s3_reg, s3_next;

  logic v1_reg, v2_reg, v3_reg;
  logic adv1, adv2, adv3;
  logic accept;

  // ---------------------------------------------------------------------------
  // Advance chain. The output stage is released only by out_ready; every
  // earlier stage moves when the stage after it is empty or itself moving,
  // so bubbles collapse and a full pipe shifts by one on accept+release.
  // ---------------------------------------------------------------------------
  assign adv3 = v3_reg && out_ready;
  assign adv2 = v2_reg && (!v3_reg || adv3);
  assign adv1 = v1_reg && (!v2_reg || adv2);

  // Held low for the whole time rst is asserted, not just after the edge.
  assign in_ready = !rst && (!v1_reg || adv1);
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // S1: absolute values and sort
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sort_x, sort_y;

  sra_abs_sort #(
    .WIDTH (WIDTH)
  ) u_abs_sort (
    .a (in_a),
    .b (in_b),
    .x (sort_x),
    .y (sort_y)
  );

  always_comb begin
    s1_next     = '0;
    s1_next.x   = sort_x;
    s1_next.y   = sort_y;
    s1_next.tag = in_tag;
  end

  // ---------------------------------------------------------------------------
  // S2: scaled terms. x_term <= x always holds, so p never underflows.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] x_term, y_term;

`ifdef SRA_ROUND_EN
  // One extra bit absorbs the rounding bias; the shifted result is back
  // within WIDTH bits because x, y <= 2^(WIDTH-1).
  logic [WIDTH:0] x_biased, y_biased;

  assign x_biased = {1'b0, s1_reg.x} + WP1'(1 << (SRA_SHIFT_X - 1));
  assign y_biased = {1'b0, s1_reg.y} + WP1'(1 << (SRA_SHIFT_Y - 1));
  assign x_term   = WIDTH'(x_biased >> SRA_SHIFT_X);
  assign y_term   = WIDTH'(y_biased >> SRA_SHIFT_Y);
`else
  assign x_term = s1_reg.x >> SRA_SHIFT_X;
  assign y_term = s1_reg.y >> SRA_SHIFT_Y;
`endif

  always_comb begin
    s2_next     = '0;
    s2_next.x   = s1_reg.x;
    s2_next.p   = s1_reg.x - x_term;
    s2_next.q   = y_term;
    s2_next.tag = s1_reg.tag;
  end

  // ---------------------------------------------------------------------------
  // S3: sum and final max against x. t peaks at 1.375 * 2^(WIDTH-1), so the
  // WIDTH+1-bit sum cannot overflow.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0] t_sum, x_ext;

  assign t_sum = {1'b0, s2_reg.p} + {1'b0, s2_reg.q};
  assign x_ext = {1'b0, s2_reg.x};

  always_comb begin
    s3_next     = '0;
    s3_next.mag = (t_sum >= x_ext) ? t_sum : x_ext;
    s3_next.tag = s2_reg.tag;
  end

  // ---------------------------------------------------------------------------
  // Stage registers and valid chain. Data registers load only when their
  // stage takes a new sample, so a stalled output holds its value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
      v3_reg <= 1'b0;
      s1_reg <= '0;
      s2_reg <= '0;
      s3_reg <= '0;
    end else begin
      if (accept) begin
        s1_reg <= s1_next;
      end
      if (adv1) begin
        s2_reg <= s2_next;
      end
      if (adv2) begin
        s3_reg <= s3_next;
      end
      v1_reg <= accept | (v1_reg & ~adv1);
      v2_reg <= adv1   | (v2_reg & ~adv2);
      v3_reg <= adv2   | (v3_reg & ~adv3);
    end
  end

  assign out_valid = v3_reg;
  assign out_mag   = s3_reg.mag;
  assign out_tag   = s3_reg.tag;

endmodule

// File: tb/tb_sra_pipe_unit.sv
// -----------------------------------------------------------------------------
// tb_sra_pipe_unit
// Scoreboard bench for sra_pipe_unit (WIDTH=16, TAG_W=4). The stimulus
// process pushes the hand-computed result of every accepted sample into a
// queue; an independent monitor pops and compares each released result and
// checks that a stalled output holds still. Expected values that differ
// between builds are selected with SRA_ROUND_EN.
// -----------------------------------------------------------------------------
module tb_sra_pipe_unit;

  localparam int WIDTH = 16;
  localparam int TAG_W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH:0]     out_mag;
  logic [TAG_W-1:0]   out_tag;

  sra_pipe_unit #(
    .WIDTH (WIDTH),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mag   (out_mag),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH:0]   mag;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   accepts = 0;
  int   waits = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Directed stream table: x mod 8 < 4 and y even, so both builds agree.
  int          st_a [10] = '{8, 16, -24, 32, 0, 48, -56, 64, 1000, -2000};
  int          st_b [10] = '{0, 8, 10, -32, -40, 2, -20, 64, -500, 1200};
  int          st_m [10] = '{8, 18, 26, 44, 40, 48, 59, 88, 1125, 2350};

`ifdef SRA_ROUND_EN
  localparam int EXP_100 = 137;
`else
  localparam int EXP_100 = 138;
`endif

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Present one sample from the falling edge until it is accepted.
  task automatic send(input int a, input int b, input int tag, input int mag);
    logic rdy;
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = WIDTH'(a);
    in_b     = WIDTH'(b);
    in_tag   = TAG_W'(tag);
    forever begin
      #1 rdy = in_ready;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 200) begin
        total++;
        bad++;
        $display("FAIL send_timeout: tag %0d not accepted after %0d cycles", tag, n);
        #1 in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    e.mag = (WIDTH+1)'(mag);
    e.tag = TAG_W'(tag);
    sb.push_back(e);
    accepts++;
    waits += n;
    $display("send a=%0d b=%0d tag=%0d expect=%0d", a, b, tag, mag);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: compares released results and checks stalled outputs hold.
  initial begin : monitor
    logic           hold;
    logic [WIDTH:0] hmag;
    logic [TAG_W-1:0] htag;
    exp_t           e;
    hold = 1'b0;
    hmag = '0;
    htag = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        hold = 1'b0;
        continue;
      end
      if (hold) begin
        total++;
        if (!(out_valid && out_mag == hmag && out_tag == htag)) begin
          bad++;
          $display("FAIL hold_stable: got valid=%0b mag=%0d tag=%0d expected valid=1 mag=%0d tag=%0d",
                   out_valid, out_mag, out_tag, hmag, htag);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_result: got mag=%0d tag=%0d expected no result", out_mag, out_tag);
        end else begin
          e = sb.pop_front();
          pop_cyc.push_back(cyc);
          if (out_mag != e.mag || out_tag != e.tag) begin
            bad++;
            $display("FAIL result: got mag=%0d tag=%0d expected mag=%0d tag=%0d",
                     out_mag, out_tag, e.mag, e.tag);
          end else begin
            $display("recv mag=%0d tag=%0d", out_mag, out_tag);
          end
        end
      end
      hold = out_valid && !out_ready;
      hmag = out_mag;
      htag = out_tag;
    end
  end

  initial begin : stimulus
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;

    // Reset state
    #3;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_mag", int'(out_mag), 0);
    check("rst_out_tag", int'(out_tag), 0);
    check("rst_in_ready", int'(in_ready), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // First sample and its latency
    send(3, 4, 1, 5);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    check("latency", n, 3);
    drain();

    // Directed corner values
    send(100, 100, 2, EXP_100);
    send(-8, 0, 3, 8);
    send(-32768, -32768, 4, 45056);
    send(-32768, 0, 5, 32768);
    send(0, 0, 6, 0);
    send(7, -7, 7, 10);
    drain();

    // Back-to-back stream of 10
    pop_cyc.delete();
    waits = 0;
    for (int i = 0; i < 10; i++) send(st_a[i], st_b[i], i, st_m[i]);
    drain();
    check("stream_waits", waits, 0);
    check("stream_count", pop_cyc.size(), 10);
    if (pop_cyc.size() == 10) check("stream_consecutive", pop_cyc[9] - pop_cyc[0], 9);

    // Backpressure: out_ready low for 6 cycles during a stream
    accepts = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(st_a[i], st_b[i], i, st_m[i]);
      end
      begin
        @(negedge clk);
        out_ready = 1'b0;
        repeat (6) @(negedge clk);
        check("bp_accepts", accepts, 3);
        check("bp_in_ready", int'(in_ready), 0);
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_all_accepted", accepts, 8);

    // Reset with three samples in flight
    @(negedge clk);
    out_ready = 1'b0;
    send(3, 4, 10, 5);
    send(100, 100, 11, EXP_100);
    send(-8, 0, 12, 8);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    check("midrst_out_mag", int'(out_mag), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);

    // Recovery after reset
    send(3, 4, 9, 5);
    drain();
    check("final_scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
